allocate: RTL and testbench



---
 rtl/allocate_if.sv | 52 +++++
 rtl/allocate.sv | 127 ++++++++++++
 tb/tb_allocate.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/allocate_if.sv
`default_nettype none
// ============================================================================
// Module      : allocate_if
// Description : Bundles the word-reader side (*_r), the allocator output side
//               (*_a), the packet arming pulse and the packet status flag into
//               one interface.
//               slave  : the allocator's view (reads *_r and sop_in, drives
//                        *_a and packet_in_progress).
//               master : the upstream/downstream view (opposite directions).
//               Signals:
//                 sop_in             start-of-packet pulse
//                 word_r             incoming packed data word
//                 new_word_r         word_r valid this cycle
//                 first_word_r       word_r is the first word of a packet
//                 last_word_r        word_r is the last word of a packet
//                 word_a             {carry, word_r}, left-justified window
//                 num_values_a       complete values held in word_a
//                 new_word_a         word_a/num_values_a updated this cycle
//                 first_word_a       first flag of the accepted word
//                 last_word_a        last flag of the accepted word
//                 packet_in_progress packet armed and not yet finished
// Revision    : 1.0 - initial release
// ============================================================================
interface allocate_if #(
   parameter int WORD_W = 32,
   parameter int OUT_W  = 38
);
   logic              sop_in;
   logic [WORD_W-1:0] word_r;
   logic              new_word_r;
   logic              first_word_r;
   logic              last_word_r;
   logic [OUT_W-1:0]  word_a;
   logic [5:0]        num_values_a;
   logic              new_word_a;
   logic              first_word_a;
   logic              last_word_a;
   logic              packet_in_progress;

   modport slave (
      input  sop_in, word_r, new_word_r, first_word_r, last_word_r,
      output word_a, num_values_a, new_word_a, first_word_a, last_word_a,
             packet_in_progress
   );

   modport master (
      output sop_in, word_r, new_word_r, first_word_r, last_word_r,
      input  word_a, num_values_a, new_word_a, first_word_a, last_word_a,
             packet_in_progress
   );
endinterface
`default_nettype wire

// File: rtl/allocate.sv
`default_nettype none
// ============================================================================
// Module      : allocate
// Description : Bit-allocation stage of the serializer datapath. Each accepted
//               32-bit word is prefixed with the 0..6 bits left over from the
//               previous word and presented as a left-justified 38-bit window,
//               together with the number of complete 7-bit values it holds.
//               Ports:
//                 clk  - system clock, rising edge
//                 rst  - synchronous active-high reset
//                 bus  - allocate_if.slave: *_r inputs, sop_in, *_a outputs,
//                        packet_in_progress
// Revision    : 1.0 - initial release
// ============================================================================
module allocate #(
   parameter int WORD_W  = 32,
   parameter int VAL_W   = 7,
   parameter int CARRY_W = VAL_W - 1,
   parameter int OUT_W   = WORD_W + CARRY_W
) (
   input  wire logic   clk,
   input  wire logic   rst,
   allocate_if.slave   bus
);

   // Width of the carry count and of the running bit total.
   localparam int c_cnt_w = $clog2(VAL_W);
   localparam int c_tot_w = $clog2(OUT_W + 1);

   localparam logic [c_cnt_w-1:0] c_carry_max = c_cnt_w'(CARRY_W);
   localparam logic [c_tot_w-1:0] c_word_bits = c_tot_w'(WORD_W);
   localparam logic [c_tot_w-1:0] c_val_bits  = c_tot_w'(VAL_W);

   logic [OUT_W-1:0]   word_a_q,       word_a_d;
   logic [5:0]         num_values_q,   num_values_d;
   logic               new_word_q,     new_word_d;
   logic               first_word_q,   first_word_d;
   logic               last_word_q,    last_word_d;
   logic               pip_q,          pip_d;
   logic [c_cnt_w-1:0] c_q,            c_d;
   logic [CARRY_W-1:0] carry_q,        carry_d;

   logic               accept;
   logic [c_cnt_w-1:0] c_eff;
   logic [c_cnt_w-1:0] c_new;
   logic [c_tot_w-1:0] total;
   logic [c_tot_w-1:0] nvals;
   logic [OUT_W-1:0]   window;
   logic [CARRY_W-1:0] carry_mask;

   always_comb begin
      accept = bus.new_word_r & pip_q;

      // A first word starts a fresh bit stream; any stale carry is dropped.
      c_eff = bus.first_word_r ? '0 : c_q;
      total = c_tot_w'(c_eff) + c_word_bits;
      nvals = total / c_val_bits;
      c_new = c_cnt_w'(total - nvals * c_val_bits);

      // Carry bits are kept right-aligned; shifting the concatenation left by
      // the unused carry positions pushes the stale upper carry bits out and
      // leaves the window left-justified with zero fill at the bottom.
      window = {carry_q, bus.word_r} << (c_carry_max - c_eff);

      // Keep only the c_new least-significant bits of the word as carry.
      carry_mask = {CARRY_W{1'b1}} >> (c_carry_max - c_new);

      word_a_d     = word_a_q;
      num_values_d = num_values_q;
      new_word_d   = 1'b0;
      first_word_d = 1'b0;
      last_word_d  = 1'b0;
      pip_d        = pip_q;
      c_d          = c_q;
      carry_d      = carry_q;

      if (accept) begin
         word_a_d     = window;
         num_values_d = 6'(nvals);
         new_word_d   = 1'b1;
         first_word_d = bus.first_word_r;
         last_word_d  = bus.last_word_r;
         if (bus.last_word_r) begin
            // Leftover bits of the last word are padding.
            c_d     = '0;
            carry_d = '0;
            pip_d   = 1'b0;
         end else begin
            c_d     = c_new;
            carry_d = bus.word_r[CARRY_W-1:0] & carry_mask;
         end
      end else if (!pip_q && bus.sop_in) begin
         pip_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         word_a_q     <= '0;
         num_values_q <= '0;
         new_word_q   <= 1'b0;
         first_word_q <= 1'b0;
         last_word_q  <= 1'b0;
         pip_q        <= 1'b0;
         c_q          <= '0;
         carry_q      <= '0;
      end else begin
         word_a_q     <= word_a_d;
         num_values_q <= num_values_d;
         new_word_q   <= new_word_d;
         first_word_q <= first_word_d;
         last_word_q  <= last_word_d;
         pip_q        <= pip_d;
         c_q          <= c_d;
         carry_q      <= carry_d;
      end
   end

   assign bus.word_a             = word_a_q;
   assign bus.num_values_a       = num_values_q;
   assign bus.new_word_a         = new_word_q;
   assign bus.first_word_a       = first_word_q;
   assign bus.last_word_a        = last_word_q;
   assign bus.packet_in_progress = pip_q;

endmodule
`default_nettype wire

// File: tb/tb_allocate.sv
`default_nettype none
// ============================================================================
// Module      : tb_allocate
// Description : Self-checking bench for allocate. A bit-queue reference model
//               tracks the packed bit stream; directed packets with known
//               windows are followed by randomized packets, gaps, resets and
//               stray sop/new_word pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_allocate;

   logic clk = 1'b0;
   logic rst;

   allocate_if bus ();

   allocate dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fails  = 0;

   // Reference model state
   bit          m_pip;
   logic [37:0] m_word;
   int          m_nv;
   bit          m_new, m_first, m_last;
   bit          m_q[$];

   logic [31:0] pkt   [4] = '{32'hF00CC05A, 32'h7D000007, 32'h00000020, 32'hFE000000};
   logic [37:0] exp_w [4] = '{38'h3C03301680, 38'h29F400001C, 38'h2000000400, 38'h01FC000000};
   int          exp_n [4] = '{4, 5, 4, 5};

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Bit stream model: the carry is simply the unconsumed tail of a queue.
   task automatic model_step(input bit r, input bit s, input bit nw, input bit f,
                             input bit l, input logic [31:0] w);
      if (r) begin
         m_pip = 0; m_word = '0; m_nv = 0;
         m_new = 0; m_first = 0; m_last = 0;
         m_q.delete();
      end else begin
         m_new = 0; m_first = 0; m_last = 0;
         if (nw && m_pip) begin
            if (f) m_q.delete();
            for (int i = 31; i >= 0; i--) m_q.push_back(w[i]);
            m_word = '0;
            foreach (m_q[i]) m_word[37-i] = m_q[i];
            m_nv = m_q.size() / 7;
            repeat (7 * m_nv) void'(m_q.pop_front());
            m_new = 1; m_first = f; m_last = l;
            if (l) begin
               m_q.delete();
               m_pip = 0;
            end
         end else if (!m_pip && s) begin
            m_pip = 1;
         end
      end
   endtask

   task automatic step(input bit r, input bit s, input bit nw, input bit f,
                       input bit l, input logic [31:0] w);
      rst              = r;
      bus.sop_in       = s;
      bus.new_word_r   = nw;
      bus.first_word_r = f;
      bus.last_word_r  = l;
      bus.word_r       = w;
      @(posedge clk);
      #1;
      model_step(r, s, nw, f, l, w);
      check_eq("word_a",             64'(bus.word_a),       64'(m_word));
      check_eq("num_values_a",       64'(bus.num_values_a), 64'(m_nv));
      check_eq("new_word_a",         64'(bus.new_word_a),   64'(m_new));
      check_eq("first_word_a",       64'(bus.first_word_a), 64'(m_first));
      check_eq("last_word_a",        64'(bus.last_word_a),  64'(m_last));
      check_eq("packet_in_progress", 64'(bus.packet_in_progress), 64'(m_pip));
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 32'h0);
   endtask

   // Sends the reference four-word packet and checks the known windows.
   task automatic run_pkt(input int gap, input bit sop_noise, input string tag);
      step(0, 1, 0, 0, 0, 32'h0);
      check_eq({tag, "_armed"}, 64'(bus.packet_in_progress), 64'd1);
      for (int i = 0; i < 4; i++) begin
         step(0, sop_noise, 1, i == 0, i == 3, pkt[i]);
         check_eq({tag, "_word"}, 64'(bus.word_a), 64'(exp_w[i]));
         check_eq({tag, "_nv"},   64'(bus.num_values_a), 64'(exp_n[i]));
         check_eq({tag, "_new"},  64'(bus.new_word_a), 64'd1);
         check_eq({tag, "_pip"},  64'(bus.packet_in_progress), (i == 3) ? 64'd0 : 64'd1);
         if (i == 3) check_eq({tag, "_last"}, 64'(bus.last_word_a), 64'd1);
         repeat (gap) idle();
      end
   endtask

   initial begin
      int len;
      bit f;

      rst = 1'b1;
      bus.sop_in = 0; bus.new_word_r = 0; bus.first_word_r = 0;
      bus.last_word_r = 0; bus.word_r = '0;

      // Reset state
      step(1, 0, 0, 0, 0, 32'h0);
      check_eq("rst_word", 64'(bus.word_a), 64'd0);
      check_eq("rst_pip",  64'(bus.packet_in_progress), 64'd0);

      // Word while idle is ignored
      step(0, 0, 1, 1, 0, 32'hF00CC05A);
      check_eq("idle_new", 64'(bus.new_word_a), 64'd0);
      check_eq("idle_pip", 64'(bus.packet_in_progress), 64'd0);

      run_pkt(1, 0, "gap");
      run_pkt(0, 0, "b2b");

      // Packet ending with leftover bits, then the reference packet
      step(0, 1, 0, 0, 0, 32'h0);
      step(0, 0, 1, 1, 0, 32'hF00CC05A);
      step(0, 0, 1, 0, 1, 32'h7D000007);
      run_pkt(0, 0, "flush");

      // first_word_r mid-packet drops a non-zero carry
      step(0, 1, 0, 0, 0, 32'h0);
      step(0, 0, 1, 1, 0, 32'h7D000007);
      step(0, 0, 1, 1, 1, 32'hF00CC05A);
      check_eq("refirst_word", 64'(bus.word_a), 64'h3C03301680);

      // Single-word packet
      step(0, 1, 0, 0, 0, 32'h0);
      step(0, 0, 1, 1, 1, 32'hFFFFFFFF);
      check_eq("single_word", 64'(bus.word_a), 64'h3FFFFFFFC0);
      check_eq("single_nv",   64'(bus.num_values_a), 64'd4);
      check_eq("single_pip",  64'(bus.packet_in_progress), 64'd0);

      // Mid-packet reset, then a clean packet with sop noise
      step(0, 1, 0, 0, 0, 32'h0);
      step(0, 0, 1, 1, 0, pkt[0]);
      step(0, 0, 1, 0, 0, pkt[1]);
      step(1, 0, 0, 0, 0, 32'h0);
      check_eq("midrst_pip",  64'(bus.packet_in_progress), 64'd0);
      check_eq("midrst_word", 64'(bus.word_a), 64'd0);
      run_pkt(0, 1, "restart");

      // Randomized packets
      for (int p = 0; p < 80; p++) begin
         len = $urandom_range(1, 6);
         if ($urandom_range(0, 9) == 0) step(1, 0, 0, 0, 0, 32'h0);
         if ($urandom_range(0, 3) == 0)
            step(0, 0, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
         step(0, 1, 0, 0, 0, 32'h0);
         for (int i = 0; i < len; i++) begin
            if (i == 0) f = ($urandom_range(0, 7) != 0);
            else        f = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 39) == 0) step(1, 0, 0, 0, 0, 32'h0);
            step(0, $urandom_range(0, 3) == 0, 1, f, i == len - 1, $urandom);
            repeat ($urandom_range(0, 2))
               step(0, 1'($urandom_range(0, 1)), 0, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), $urandom);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
`default_nettype wire
